// File: rtl/rule_110_pkg.sv
// Shared rule 110 definitions: the local rule, pair encodings and search states.
// The forward stepper and the preimage search both import this package.
package rule_110_pkg;

  localparam logic [1:0] PAIR_00 = 2'b00;
  localparam logic [1:0] PAIR_01 = 2'b01;
  localparam logic [1:0] PAIR_10 = 2'b10;
  localparam logic [1:0] PAIR_11 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2
  } state_e;

  // right is x[i-1], center is x[i], left is x[i+1]
  function automatic logic rule_f(input logic left, input logic center, input logic right);
    return (right ^ center) | (~left & right);
  endfunction

endpackage

// File: rtl/rule_110_pair_step.sv
// One de Bruijn step: maps the set of pairs (x[i-1],x[i]) reachable at cell i to
// the set of pairs (x[i],x[i+1]) that also reproduce target bit i.
module rule_110_pair_step
  import rule_110_pkg::*;
(
  input  logic [3:0] reach_in,
  input  logic       tgt,
  input  logic       last,
  output logic [3:0] reach_out
);

  always_comb begin
    reach_out = '0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 2; c++) begin
        // past the last cell the zero boundary forbids c=1
        if (reach_in[s] && !(last && (c == 1)) && (rule_f(c[0], s[0], s[1]) == tgt))
          reach_out[{s[0], c[0]}] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rule_110_preimage.sv
// Rule 110 predecessor search: a forward pass fills reach[0..LEN], then a
// prefer-0 traceback rebuilds one predecessor row, or reports an orphan row.
module rule_110_preimage
  import rule_110_pkg::*;
#(
  parameter int LEN = 512
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [LEN-1:0] data,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [LEN-1:0] q
);

  localparam int IW = $clog2(LEN + 1);
  localparam int TW = $clog2(LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
  localparam logic [IW-1:0] END_IDX  = IW'(LEN);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [LEN-1:0] target_q, target_d;
  logic [LEN-1:0] q_q, q_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           found_q, found_d;
  logic           x_cur_q, x_cur_d;
  logic           x_nxt_q, x_nxt_d;
  logic [3:0]     reach_q [0:LEN];
  logic [3:0]     reach_d [0:LEN];

  logic [3:0]     reach_rd;
  logic [3:0]     step_out;
  logic [IW-1:0]  idx_m1;
  logic [TW-1:0]  tidx;
  logic [TW-1:0]  qidx;
  logic           tgt_bit;
  logic           pick;

  assign reach_rd = reach_q[idx_q];
  assign idx_m1   = idx_q - IW'(1);
  assign tidx     = idx_q[TW-1:0];
  assign qidx     = idx_m1[TW-1:0];
  assign tgt_bit  = target_q[tidx];

  // x[idx-1]=0 is kept only if pair (0,x[idx]) is reachable and reproduces target[idx]
  assign pick = ~(reach_rd[{1'b0, x_cur_q}] && (rule_f(x_nxt_q, x_cur_q, 1'b0) == tgt_bit));

  rule_110_pair_step u_pair_step (
    .reach_in  (reach_rd),
    .tgt       (tgt_bit),
    .last      (idx_q == LAST_IDX),
    .reach_out (step_out)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    q_d      = q_q;
    found_d  = found_q;
    done_d   = 1'b0;
    x_cur_d  = x_cur_q;
    x_nxt_d  = x_nxt_q;
    reach_d  = reach_q;
    case (state_q)
      IDLE: begin
        // a start coinciding with the done pulse is deliberately dropped
        if (start && !done_q) begin
          target_d            = data;
          reach_d[0]          = '0;
          reach_d[0][PAIR_00] = 1'b1;
          reach_d[0][PAIR_01] = 1'b1;
          idx_d               = '0;
          found_d             = 1'b0;
          state_d             = FWD;
        end
      end
      FWD: begin
        if (idx_q != END_IDX) begin
          reach_d[idx_q + IW'(1)] = step_out;
          idx_d                   = idx_q + IW'(1);
        end else if (reach_rd == 4'b0000) begin
          done_d  = 1'b1;
          found_d = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          x_cur_d      = ~reach_rd[PAIR_00];
          x_nxt_d      = 1'b0;
          q_d[LEN-1]   = ~reach_rd[PAIR_00];
          idx_d        = LAST_IDX;
          state_d      = BWD;
        end
      end
      BWD: begin
        if (idx_q == '0) begin
          done_d  = 1'b1;
          found_d = 1'b1;
          state_d = IDLE;
        end else begin
          q_d[qidx] = pick;
          x_nxt_d   = x_cur_q;
          x_cur_d   = pick;
          idx_d     = idx_m1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FWD) || (state_d == BWD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      target_q <= '0;
      q_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      x_cur_q  <= 1'b0;
      x_nxt_q  <= 1'b0;
      for (int i = 0; i <= LEN; i++) reach_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      q_q      <= q_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      x_cur_q  <= x_cur_d;
      x_nxt_q  <= x_nxt_d;
      reach_q  <= reach_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign q     = q_q;

endmodule

// File: doc/rule_110_preimage.md
Name: rule_110_preimage

Overview:
- Inverse of the rule 110 stepper. Given a target row, the block searches for a predecessor row x such that one rule 110 step of x gives the target.
- Boundaries are zero, the same convention as the forward stepper: x[-1]=0 and x[LEN]=0.
- Bit-serial de Bruijn search:
  - forward pass builds the reachable-state sets;
  - backward traceback reconstructs one predecessor, or the block reports that the target is a Garden-of-Eden (orphan) row.
- Sits beside the stepper for pattern generation and for self-check of stepper runs.

Parameters:
- LEN, 512, row width in cells; must be >= 3.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- data  input  LEN  target row; captured on the edge where start is accepted.
- busy  output  1  high while the search runs (FWD or BWD state).
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  1 = predecessor exists; held until the next accepted start.
- q  output  LEN  predecessor row; valid when found=1; held until the next accepted start.

Behaviour:
- Rule:
  - new[i] = (x[i-1] ^ x[i]) | (~x[i+1] & x[i-1]).
  - Cell i has right neighbour x[i-1] and left neighbour x[i+1].
- Search state:
  - Pair s=(x[i-1],x[i]), encoded 2'b{x[i-1],x[i]}.
  - reach[i] is a 4-bit set of the pairs consistent with target bits 0..i-1.
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, found=0, q=0.
  - reach storage and the index counter are cleared.
  - Reset mid-search aborts immediately; no done pulse is produced.
- IDLE:
  - start=1 captures data into the target register.
  - Sets reach[0]={00,01} (x[-1]=0, x[0] free) and idx=0, then moves to FWD.
  - start while busy is ignored and does not disturb the running search.
- FWD, one cell per cycle, idx=0..LEN-1:
  - For each s=(a,b) in reach[idx] and each c in {0,1}: pair (b,c) enters reach[idx+1] iff f(c,b,a)==target[idx].
  - When idx=LEN-1, only c=0 is allowed (x[LEN]=0).
  - After idx=LEN-1, if reach[LEN] is empty: found=0, done=1 next cycle, return to IDLE (LEN+1 cycles after start).
  - Otherwise go to BWD.
- BWD, one cell per cycle, idx=LEN-1 down to 0:
  - Start from the final pair (x[LEN-1],0). Choose x[LEN-1]=0 if pair 00 is in reach[LEN], else 1.
  - At each step, choose x[idx-1]: prefer 0 if pair (0,x[idx]) is in reach[idx] and is consistent with target[idx] given x[idx+1]; else choose 1.
  - The chosen bit is written into q[idx-1].
  - Tie-break is fixed (prefer 0 going downward), so the result is deterministic.
  - After idx=0: found=1, done=1 for one cycle, return to IDLE.
  - Total latency is 2*LEN+1 cycles from start acceptance to done.
- Outputs:
  - q and found are registered and stable between done and the next accepted start.
  - start in the same cycle as done is not accepted; it is accepted on the following IDLE cycle.
- Correctness invariant: when found=1, one forward rule 110 step of q equals the captured target, bit-exact.
- Storage: reach is LEN+1 entries x 4 bits of flops. The traceback reads reach[idx] combinationally, indexed by the counter.

Decomposition:
- Shared package (rule_110_pkg):
  - the rule function f(left,center,right) returning one bit;
  - pair encoding constants PAIR_00..PAIR_11;
  - the state enum IDLE/FWD/BWD.
- The package is shared with the forward stepper so both use one rule definition.
- Sub-module rule_110_pair_step (combinational):
  - inputs: 4-bit reach set, target bit, last-cell flag;
  - output: next 4-bit reach set;
  - the backward chooser reuses the same rule function.

Test Plan:
- LEN=8, data=8'h00 -> done after 17 cycles, found=1, q=8'h00.
- LEN=8, data=8'h01 (orphan: bit 0 forces x[7:0]=8'hFF, whose step is not 8'h01) -> done after 9 cycles, found=0, busy deasserted.
- LEN=8, data=8'h03 -> found=1; step(q)==8'h03; q matches the bit-accurate model that uses the same prefer-0 tie-break.
- LEN=16, 200 random x: feed data=step(x) -> found=1 every time and step(q)==data. Random data rows -> found matches the exhaustive software preimage check.
- Async reset:
  - pulse rst_n low during FWD at idx=3 -> busy=0, done=0, q=0 immediately; no done pulse follows.
  - a subsequent start with 8'h00 completes normally.
- start held high for the whole search, plus start on the done cycle -> exactly one search runs; the next search begins on the first IDLE cycle after done.
